// File: rtl/sensor_hub_pkg.sv
// Shared opcodes, status bytes, state encoding and 40-bit frame layout for the
// multi-channel sensor hub decoder.
package sensor_hub_pkg;

    localparam logic [7:0] OP_STATUS    = 8'h00;
    localparam logic [7:0] OP_TEMP_INT  = 8'h01;
    localparam logic [7:0] OP_TEMP_FRAC = 8'h02;
    localparam logic [7:0] OP_HUM_INT   = 8'h03;
    localparam logic [7:0] OP_HUM_FRAC  = 8'h04;
    localparam logic [7:0] OP_STREAM_T  = 8'h05;
    localparam logic [7:0] OP_STREAM_H  = 8'h06;
    localparam logic [7:0] OP_STOP_A    = 8'h07;
    localparam logic [7:0] OP_STOP_B    = 8'h08;

    localparam logic [7:0] ST_OK    = 8'h11;
    localparam logic [7:0] ST_BAD   = 8'h10;
    localparam logic [7:0] ST_TMO   = 8'h12;
    localparam logic [7:0] ST_BADCH = 8'h1F;
    localparam logic [7:0] DATA_ERR = 8'hFF;

    // Frame layout: {hum_int, hum_frac, temp_int, temp_frac, checksum}
    localparam int FRAME_W       = 40;
    localparam int HUM_INT_LSB   = 32;
    localparam int HUM_FRAC_LSB  = 24;
    localparam int TEMP_INT_LSB  = 16;
    localparam int TEMP_FRAC_LSB = 8;
    localparam int CSUM_LSB      = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESPOND,
        S_STR_INT,
        S_STR_FRAC,
        S_STR_GAP,
        S_DONE
    } hub_state_e;

    typedef enum logic [1:0] {
        RES_OK,
        RES_ERR,
        RES_TMO
    } hub_result_e;

    typedef struct packed {
        logic [7:0] hum_int;
        logic [7:0] hum_frac;
        logic [7:0] temp_int;
        logic [7:0] temp_frac;
    } reading_t;

    function automatic logic is_stream_op(input logic [7:0] op);
        return (op == OP_STREAM_T) || (op == OP_STREAM_H);
    endfunction

endpackage

// File: rtl/sensor_frame_check.sv
// Splits a 40-bit sensor frame into its four data bytes and checks the
// trailing byte against their 8-bit wrapping sum.
module sensor_frame_check
    import sensor_hub_pkg::*;
(
    input  logic [FRAME_W-1:0] i_frame,
    output reading_t           o_reading,
    output logic               o_csum_ok
);

    logic [7:0] w_sum;

    assign o_reading.hum_int   = i_frame[HUM_INT_LSB   +: 8];
    assign o_reading.hum_frac  = i_frame[HUM_FRAC_LSB  +: 8];
    assign o_reading.temp_int  = i_frame[TEMP_INT_LSB  +: 8];
    assign o_reading.temp_frac = i_frame[TEMP_FRAC_LSB +: 8];

    assign w_sum     = o_reading.hum_int + o_reading.hum_frac
                     + o_reading.temp_int + o_reading.temp_frac;
    assign o_csum_ok = (w_sum == i_frame[CSUM_LSB +: 8]);

endmodule

// File: rtl/sensor_hub_decoder.sv
// Arbitrates NUM_CHANNELS sensor drivers behind one request/response port,
// with timeout, checksum status and periodic streaming.
// Optional last-good-frame cache per channel: define SENSOR_HUB_LAST_GOOD_EN.
module sensor_hub_decoder
    import sensor_hub_pkg::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int CH_W           = 5,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int STREAM_PERIOD  = 100_000_000
) (
    input  logic                            i_clock,
    input  logic                            i_reset_n,
    input  logic                            i_enable,
    input  logic [CH_W-1:0]                 i_channel,
    input  logic [7:0]                      i_request,
    output logic [NUM_CHANNELS-1:0]         o_sensor_start,
    input  logic [FRAME_W*NUM_CHANNELS-1:0] i_sensor_data,
    input  logic [NUM_CHANNELS-1:0]         i_sensor_done,
    input  logic [NUM_CHANNELS-1:0]         i_sensor_error,
    output logic [7:0]                      o_requested_data,
    output logic                            o_data_strobe,
    output logic                            o_finished
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PER_W = $clog2(STREAM_PERIOD + 1);
    localparam logic [CH_W:0]    LP_NUM_CH   = (CH_W + 1)'(NUM_CHANNELS);
    localparam logic [TMO_W-1:0] LP_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PER_W-1:0] LP_PER_LAST = PER_W'(STREAM_PERIOD - 1);

    hub_state_e                r_state,      w_next_state;
    logic [CH_W-1:0]           r_ch,         w_next_ch;
    logic [7:0]                r_op,         w_next_op;
    hub_result_e               r_result,     w_next_result;
    reading_t                  r_reading,    w_next_reading;
    logic                      r_reading_ok, w_next_reading_ok;
    logic                      r_csum_ok,    w_next_csum_ok;
    logic [NUM_CHANNELS-1:0]   r_start,      w_next_start;
    logic [7:0]                r_data,       w_next_data;
    logic                      r_strobe,     w_next_strobe;
    logic                      r_finished,   w_next_finished;
    logic [TMO_W-1:0]          r_tcnt,       w_next_tcnt;
    logic [PER_W-1:0]          r_pcnt,       w_next_pcnt;

    logic                    w_sel_done;
    logic                    w_sel_error;
    logic [FRAME_W-1:0]      w_sel_frame;
    logic [NUM_CHANNELS-1:0] w_sel_onehot;
    reading_t                w_reading;
    logic                    w_csum_ok;
    reading_t                w_fallback;
    logic                    w_fallback_ok;
    logic                    w_stop;
    hub_state_e              w_exit_state;
    logic [7:0]              w_resp_byte;
    logic [7:0]              w_int_byte;
    logic [7:0]              w_frac_byte;

    always_comb begin
        w_sel_done   = 1'b0;
        w_sel_error  = 1'b0;
        w_sel_frame  = '0;
        w_sel_onehot = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (r_ch == CH_W'(k)) begin
                w_sel_done      = i_sensor_done[k];
                w_sel_error     = i_sensor_error[k];
                w_sel_frame     = i_sensor_data[FRAME_W*k +: FRAME_W];
                w_sel_onehot[k] = 1'b1;
            end
        end
    end

    sensor_frame_check u_frame_check (
        .i_frame   (w_sel_frame),
        .o_reading (w_reading),
        .o_csum_ok (w_csum_ok)
    );

`ifdef SENSOR_HUB_LAST_GOOD_EN
    reading_t                r_cache [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_cache_vld;
    logic                    w_cache_wr;

    assign w_cache_wr = (r_state == S_WAIT) && !w_stop && w_sel_done
                      && !w_sel_error && w_csum_ok;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NUM_CHANNELS; k++) r_cache[k] <= '0;
            r_cache_vld <= '0;
        end else if (w_cache_wr) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                if (w_sel_onehot[k]) begin
                    r_cache[k]     <= w_reading;
                    r_cache_vld[k] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_fallback    = '0;
        w_fallback_ok = 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (w_sel_onehot[k]) begin
                w_fallback    = r_cache[k];
                w_fallback_ok = r_cache_vld[k];
            end
        end
    end
`else
    assign w_fallback    = '0;
    assign w_fallback_ok = 1'b0;
`endif

    // Stop codes are honoured only while a streaming transaction is live.
    assign w_stop = is_stream_op(r_op)
                  && ((i_request == OP_STOP_A) || (i_request == OP_STOP_B))
                  && ((r_state == S_START) || (r_state == S_WAIT)
                      || (r_state == S_STR_INT) || (r_state == S_STR_FRAC)
                      || (r_state == S_STR_GAP));

    assign w_exit_state = is_stream_op(r_op) ? S_STR_INT : S_RESPOND;
    assign w_int_byte   = (r_op == OP_STREAM_H) ? r_reading.hum_int  : r_reading.temp_int;
    assign w_frac_byte  = (r_op == OP_STREAM_H) ? r_reading.hum_frac : r_reading.temp_frac;

    always_comb begin
        w_resp_byte = 8'h00;
        case (r_op)
            OP_STATUS: begin
                if (r_result == RES_TMO)                       w_resp_byte = ST_TMO;
                else if ((r_result == RES_ERR) || !r_csum_ok)  w_resp_byte = ST_BAD;
                else                                           w_resp_byte = ST_OK;
            end
            OP_TEMP_INT:  w_resp_byte = r_reading_ok ? r_reading.temp_int  : DATA_ERR;
            OP_TEMP_FRAC: w_resp_byte = r_reading_ok ? r_reading.temp_frac : DATA_ERR;
            OP_HUM_INT:   w_resp_byte = r_reading_ok ? r_reading.hum_int   : DATA_ERR;
            OP_HUM_FRAC:  w_resp_byte = r_reading_ok ? r_reading.hum_frac  : DATA_ERR;
            default:      w_resp_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_ch         = r_ch;
        w_next_op         = r_op;
        w_next_result     = r_result;
        w_next_reading    = r_reading;
        w_next_reading_ok = r_reading_ok;
        w_next_csum_ok    = r_csum_ok;
        w_next_start      = '0;
        w_next_data       = r_data;
        w_next_strobe     = 1'b0;
        w_next_finished   = 1'b0;
        w_next_tcnt       = r_tcnt;
        w_next_pcnt       = r_pcnt;

        if (w_stop) begin
            w_next_finished = 1'b1;
            w_next_state    = S_DONE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        w_next_ch = i_channel;
                        w_next_op = i_request;
                        if ({1'b0, i_channel} >= LP_NUM_CH) begin
                            w_next_data     = ST_BADCH;
                            w_next_strobe   = 1'b1;
                            w_next_finished = 1'b1;
                            w_next_state    = S_DONE;
                        end else begin
                            w_next_state = S_START;
                        end
                    end
                end
                S_START: begin
                    w_next_start = w_sel_onehot;
                    w_next_tcnt  = '0;
                    w_next_state = S_WAIT;
                end
                S_WAIT: begin
                    if (w_sel_error) begin
                        w_next_result     = RES_ERR;
                        w_next_reading    = w_fallback;
                        w_next_reading_ok = w_fallback_ok;
                        w_next_state      = w_exit_state;
                    end else if (w_sel_done) begin
                        w_next_result     = RES_OK;
                        w_next_reading    = w_reading;
                        w_next_reading_ok = 1'b1;
                        w_next_csum_ok    = w_csum_ok;
                        w_next_state      = w_exit_state;
                    end else if (r_tcnt == LP_TMO_LAST) begin
                        w_next_result     = RES_TMO;
                        w_next_reading    = w_fallback;
                        w_next_reading_ok = w_fallback_ok;
                        w_next_state      = w_exit_state;
                    end else begin
                        w_next_tcnt  = r_tcnt + 1'b1;
                        w_next_start = r_start;
                    end
                end
                S_RESPOND: begin
                    w_next_data     = w_resp_byte;
                    w_next_strobe   = 1'b1;
                    w_next_finished = 1'b1;
                    w_next_state    = S_DONE;
                end
                S_STR_INT: begin
                    w_next_strobe = 1'b1;
                    if (!r_reading_ok) begin
                        w_next_data  = DATA_ERR;
                        w_next_pcnt  = '0;
                        w_next_state = S_STR_GAP;
                    end else begin
                        w_next_data  = w_int_byte;
                        w_next_state = S_STR_FRAC;
                    end
                end
                S_STR_FRAC: begin
                    w_next_data   = w_frac_byte;
                    w_next_strobe = 1'b1;
                    w_next_pcnt   = '0;
                    w_next_state  = S_STR_GAP;
                end
                S_STR_GAP: begin
                    if (r_pcnt == LP_PER_LAST) w_next_state = S_START;
                    else                       w_next_pcnt  = r_pcnt + 1'b1;
                end
                S_DONE:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_ch         <= '0;
            r_op         <= '0;
            r_result     <= RES_OK;
            r_reading    <= '0;
            r_reading_ok <= 1'b0;
            r_csum_ok    <= 1'b0;
            r_start      <= '0;
            r_data       <= 8'h00;
            r_strobe     <= 1'b0;
            r_finished   <= 1'b0;
            r_tcnt       <= '0;
            r_pcnt       <= '0;
        end else begin
            r_state      <= w_next_state;
            r_ch         <= w_next_ch;
            r_op         <= w_next_op;
            r_result     <= w_next_result;
            r_reading    <= w_next_reading;
            r_reading_ok <= w_next_reading_ok;
            r_csum_ok    <= w_next_csum_ok;
            r_start      <= w_next_start;
            r_data       <= w_next_data;
            r_strobe     <= w_next_strobe;
            r_finished   <= w_next_finished;
            r_tcnt       <= w_next_tcnt;
            r_pcnt       <= w_next_pcnt;
        end
    end

    assign o_sensor_start   = r_start;
    assign o_requested_data = r_data;
    assign o_data_strobe    = r_strobe;
    assign o_finished       = r_finished;

endmodule

// File: tb/tb_sensor_hub_decoder.sv
// Directed self-checking bench for sensor_hub_decoder with short timeout and
// stream period so every path completes quickly.
module tb_sensor_hub_decoder;

    localparam int NCH = 4;
    localparam int CHW = 5;
    localparam int TMO = 100;
    localparam int PER = 50;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic [CHW-1:0]    channel = '0;
    logic [7:0]        request = 8'h00;
    logic [NCH-1:0]    sensor_start;
    logic [40*NCH-1:0] sensor_data = '0;
    logic [NCH-1:0]    sensor_done = '0;
    logic [NCH-1:0]    sensor_error = '0;
    logic [7:0]        requested_data;
    logic              data_strobe;
    logic              finished;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    sensor_hub_decoder #(
        .NUM_CHANNELS   (NCH),
        .CH_W           (CHW),
        .TIMEOUT_CYCLES (TMO),
        .STREAM_PERIOD  (PER)
    ) dut (
        .i_clock          (clock),
        .i_reset_n        (reset_n),
        .i_enable         (enable),
        .i_channel        (channel),
        .i_request        (request),
        .o_sensor_start   (sensor_start),
        .i_sensor_data    (sensor_data),
        .i_sensor_done    (sensor_done),
        .i_sensor_error   (sensor_error),
        .o_requested_data (requested_data),
        .o_data_strobe    (data_strobe),
        .o_finished       (finished)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction; mode 0 = driver completes, 1 = driver errors, 2 = silent.
    // Returns the negedge count from the enable edge to the finished pulse.
    task automatic applyStimulus(input logic [CHW-1:0] ch, input logic [7:0] op,
                                 input int mode, input logic [39:0] frame,
                                 output int cyc, output logic [NCH-1:0] startSeen);
        bit fired;
        fired   = 1'b0;
        enable  = 1'b1;
        channel = ch;
        request = op;
        @(negedge clock);
        enable    = 1'b0;
        cyc       = 1;
        startSeen = '0;
        while (finished !== 1'b1 && cyc < 400) begin
            sensor_done  = '0;
            sensor_error = '0;
            startSeen    = startSeen | sensor_start;
            if (sensor_start != '0 && !fired) begin
                fired = 1'b1;
                for (int k = 0; k < NCH; k++)
                    if (sensor_start[k]) sensor_data[40*k +: 40] = frame;
                if (mode == 0) sensor_done = sensor_start;
                else if (mode == 1) sensor_error = sensor_start;
            end
            @(negedge clock);
            cyc++;
        end
        sensor_done  = '0;
        sensor_error = '0;
    endtask

    initial begin
        int             cyc;
        int             cnt;
        int             stbCnt;
        logic [NCH-1:0] seen;
        logic [7:0]     expCache;
        logic [7:0]     expStr1;
        logic [7:0]     expStr2;
        logic           expStb2;

`ifdef SENSOR_HUB_LAST_GOOD_EN
        expCache = 8'h37;
        expStr1  = 8'h19;
        expStr2  = 8'h03;
        expStb2  = 1'b1;
`else
        expCache = 8'hFF;
        expStr1  = 8'hFF;
        expStr2  = 8'hFF;
        expStb2  = 1'b0;
`endif

        sensor_data = {20{8'hA5}};
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_start",  32'(sensor_start), 32'h0);
        checkOutput("rst_data",   32'(requested_data), 32'h00);
        checkOutput("rst_strobe", 32'(data_strobe), 32'h0);
        checkOutput("rst_fin",    32'(finished), 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        $display("[TB] temp_int read on channel 2");
        applyStimulus(5'd2, 8'h01, 0, 40'h37_00_19_00_50, cyc, seen);
        checkOutput("t1_fin",     32'(finished), 32'h1);
        checkOutput("t1_strobe",  32'(data_strobe), 32'h1);
        checkOutput("t1_data",    32'(requested_data), 32'h19);
        checkOutput("t1_start",   32'(seen), 32'h4);
        checkOutput("t1_latency", 32'(cyc), 32'd4);
        @(negedge clock);
        checkOutput("t1_fin_pulse", 32'(finished), 32'h0);
        checkOutput("t1_stb_pulse", 32'(data_strobe), 32'h0);
        checkOutput("t1_data_held", 32'(requested_data), 32'h19);

        $display("[TB] status with bad and good checksum");
        applyStimulus(5'd1, 8'h00, 0, 40'h37_00_19_00_51, cyc, seen);
        checkOutput("t2_bad_csum", 32'(requested_data), 32'h10);
        @(negedge clock);
        applyStimulus(5'd1, 8'h00, 0, 40'h37_00_19_00_50, cyc, seen);
        checkOutput("t2_good_csum", 32'(requested_data), 32'h11);
        @(negedge clock);
        applyStimulus(5'd1, 8'h09, 0, 40'h37_00_19_00_50, cyc, seen);
        checkOutput("t2_unknown_op", 32'(requested_data), 32'h00);
        checkOutput("t2_unknown_stb", 32'(data_strobe), 32'h1);
        @(negedge clock);
        applyStimulus(5'd3, 8'h04, 0, 40'h37_05_19_00_55, cyc, seen);
        checkOutput("t2_hum_frac", 32'(requested_data), 32'h05);
        checkOutput("t2_start3", 32'(seen), 32'h8);
        @(negedge clock);

        $display("[TB] timeout on channel 0");
        applyStimulus(5'd0, 8'h03, 2, 40'h0, cyc, seen);
        checkOutput("t3_tmo_fin", 32'(finished), 32'h1);
        checkOutput("t3_tmo_latency", 32'(cyc), 32'd103);
        checkOutput("t3_tmo_data", 32'(requested_data), 32'hFF);
        checkOutput("t3_tmo_start_off", 32'(sensor_start), 32'h0);
        @(negedge clock);
        applyStimulus(5'd0, 8'h00, 2, 40'h0, cyc, seen);
        checkOutput("t3_tmo_status", 32'(requested_data), 32'h12);
        @(negedge clock);

        $display("[TB] driver error");
        applyStimulus(5'd2, 8'h03, 1, 40'h0, cyc, seen);
        checkOutput("t4_err_hum", 32'(requested_data), 32'(expCache));
        @(negedge clock);
        applyStimulus(5'd3, 8'h00, 1, 40'h0, cyc, seen);
        checkOutput("t4_err_status", 32'(requested_data), 32'h10);
        @(negedge clock);

        $display("[TB] out-of-range channel");
        applyStimulus(5'd6, 8'h01, 0, 40'h37_00_19_00_50, cyc, seen);
        checkOutput("t5_badch_data", 32'(requested_data), 32'h1F);
        checkOutput("t5_badch_stb", 32'(data_strobe), 32'h1);
        checkOutput("t5_badch_start", 32'(seen), 32'h0);
        checkOutput("t5_badch_latency", 32'(cyc), 32'd1);
        @(negedge clock);

        $display("[TB] temperature streaming on channel 1");
        enable  = 1'b1;
        channel = 5'd1;
        request = 8'h05;
        @(negedge clock);
        enable = 1'b0;
        cnt = 0;
        while (sensor_start == '0 && cnt < 10) begin
            @(negedge clock);
            cnt++;
        end
        checkOutput("t6_start1", 32'(sensor_start), 32'h2);
        sensor_data[79:40] = 40'h37_00_19_03_53;
        sensor_done = sensor_start;
        @(negedge clock);
        sensor_done = '0;
        checkOutput("t6_no_early_stb", 32'(data_strobe), 32'h0);
        @(negedge clock);
        checkOutput("t6_int_stb", 32'(data_strobe), 32'h1);
        checkOutput("t6_int_data", 32'(requested_data), 32'h19);
        @(negedge clock);
        checkOutput("t6_frac_stb", 32'(data_strobe), 32'h1);
        checkOutput("t6_frac_data", 32'(requested_data), 32'h03);
        checkOutput("t6_no_fin", 32'(finished), 32'h0);
        cnt = 0;
        stbCnt = 0;
        do begin
            @(negedge clock);
            cnt++;
            if (data_strobe) stbCnt++;
        end while (sensor_start == '0 && cnt < 200);
        checkOutput("t6_gap_cycles", 32'(cnt), 32'd51);
        checkOutput("t6_gap_quiet", 32'(stbCnt), 32'd0);
        checkOutput("t6_restart_ch", 32'(sensor_start), 32'h2);

        sensor_error = sensor_start;
        @(negedge clock);
        sensor_error = '0;
        checkOutput("t6_err_no_early", 32'(data_strobe), 32'h0);
        @(negedge clock);
        checkOutput("t6_err_stb1", 32'(data_strobe), 32'h1);
        checkOutput("t6_err_data1", 32'(requested_data), 32'(expStr1));
        @(negedge clock);
        checkOutput("t6_err_stb2", 32'(data_strobe), 32'(expStb2));
        checkOutput("t6_err_data2", 32'(requested_data), 32'(expStr2));

        repeat (10) @(negedge clock);
        request = 8'h07;
        @(negedge clock);
        checkOutput("t6_stop_fin", 32'(finished), 32'h1);
        checkOutput("t6_stop_stb", 32'(data_strobe), 32'h0);
        checkOutput("t6_stop_start", 32'(sensor_start), 32'h0);
        request = 8'h00;
        stbCnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (data_strobe || finished || (sensor_start != '0)) stbCnt++;
        end
        checkOutput("t6_after_stop_quiet", 32'(stbCnt), 32'd0);

        $display("[TB] reset during WAIT");
        enable  = 1'b1;
        channel = 5'd0;
        request = 8'h00;
        @(negedge clock);
        enable = 1'b0;
        cnt = 0;
        while (sensor_start == '0 && cnt < 10) begin
            @(negedge clock);
            cnt++;
        end
        checkOutput("t7_start0", 32'(sensor_start), 32'h1);
        reset_n = 1'b0;
        @(negedge clock);
        checkOutput("t7_rst_start", 32'(sensor_start), 32'h0);
        checkOutput("t7_rst_data", 32'(requested_data), 32'h00);
        checkOutput("t7_rst_stb", 32'(data_strobe), 32'h0);
        checkOutput("t7_rst_fin", 32'(finished), 32'h0);
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("t7_idle_start", 32'(sensor_start), 32'h0);
        checkOutput("t7_idle_fin", 32'(finished), 32'h0);

        applyStimulus(5'd2, 8'h02, 0, 40'h37_00_19_03_53, cyc, seen);
        checkOutput("t8_temp_frac", 32'(requested_data), 32'h03);
        checkOutput("t8_latency", 32'(cyc), 32'd4);
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sensor_hub_decoder.md
Name: sensor_hub_decoder

Overview:
- Parametrised successor to the single-DHT11 sensor facade: arbitrates NUM_CHANNELS independent sensor drivers behind one request/response interface.
- Sits between the UART command decoder (client) and the per-channel sensor driver instances.
- Adds channel indexing, timeout, a correct checksum, and periodic streaming.
- Sensor drivers own their transmission lines; this block sees only start/done/error handshakes and 40-bit frames.

Parameters:
- NUM_CHANNELS, 4, number of attached sensor drivers (1..32).
- CH_W, 5, width of channel index (>= clog2(NUM_CHANNELS), minimum 1).
- TIMEOUT_CYCLES, 5_000_000, max cycles waiting for done/error (100 ms at 50 MHz).
- STREAM_PERIOD, 100_000_000, cycles between stream re-reads (2 s at 50 MHz).

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset_n  in  1  reset, synchronous, active-low.
- enable  in  1  request valid; sampled only in IDLE.
- channel  in  CH_W  sensor index for the request.
- request  in  8  opcode; also monitored during streaming for stop codes.
- sensor_start  out  NUM_CHANNELS  one-hot start level to the selected driver.
- sensor_data  in  40*NUM_CHANNELS  frames; channel k at [40k+39:40k], layout {hum_int, hum_frac, temp_int, temp_frac, checksum}.
- sensor_done  in  NUM_CHANNELS  per-driver frame-complete.
- sensor_error  in  NUM_CHANNELS  per-driver protocol error.
- requested_data  out  8  response byte, held until overwritten.
- data_strobe  out  1  one-cycle pulse per new requested_data byte.
- finished  out  1  one-cycle pulse at end of a transaction.

Behaviour:
- Reset (reset_n=0 at an edge): state IDLE, sensor_start=0, requested_data=8'h00, data_strobe=0, finished=0, timeout and period counters 0. Reset mid-operation aborts immediately with no finished pulse.
- States: IDLE, START, WAIT, RESPOND, STR_INT, STR_FRAC, STR_GAP, DONE.
- IDLE: on enable=1, latch channel/request → START. If channel >= NUM_CHANNELS: requested_data=8'h1F, data_strobe and finished pulse, → DONE; no sensor started.
- START: assert sensor_start[ch] (held through WAIT); clear timeout counter → WAIT.
- WAIT exits:
  - sensor_done[ch] → latch frame → RESPOND (or STR_INT if opcode 05/06).
  - sensor_error[ch] → status=ERR.
  - timeout counter == TIMEOUT_CYCLES-1 → status=TMO.
  - done and error in the same cycle: error wins.
- On any WAIT exit, deassert sensor_start.
- Checksum valid iff frame[7:0] == (hum_int+hum_frac+temp_int+temp_frac) mod 256, 8-bit wrap.
- RESPOND: drive requested_data, pulse data_strobe and finished in the same cycle → DONE. Opcodes:
  - 00: status byte — 8'h11 ok; 8'h10 checksum bad or error; 8'h12 timeout.
  - 01: temp_int; 02: temp_frac; 03: hum_int; 04: hum_frac.
  - Data opcodes after error/timeout return 8'hFF.
  - Any other opcode returns 8'h00.
- Total latency enable → finished = 3 cycles + sensor time.
- Streaming (05 = temp, 06 = hum):
  - STR_INT: output int byte with strobe → STR_FRAC.
  - STR_FRAC: output frac byte with strobe → STR_GAP.
  - STR_GAP: counts STREAM_PERIOD cycles, then → START on the same channel.
  - Error/timeout while streaming: emit 8'hFF once with strobe, then STR_GAP.
- Stop: request==07 or 08 observed in any stream state (including WAIT/START when streaming) → finished pulse, sensor_start=0 → DONE. Stop has priority over a same-cycle strobe; that byte is not emitted.
- DONE: one cycle, outputs quiet → IDLE. enable held high starts a new transaction on the following IDLE cycle.

Optional Feature:
- Macro: SENSOR_HUB_LAST_GOOD_EN.
- Defined:
  - Per-channel 32-bit cache of the last checksum-valid frame, plus a valid bit.
  - On error/timeout, data opcodes (01-04 and stream bytes) return cached bytes if the valid bit is set, else 8'hFF.
  - Status opcode 00 still reports the live result.
  - Cache and valid bits cleared by reset.
- Not defined: no cache; behaviour exactly as above.

Decomposition:
- Package sensor_hub_pkg holds:
  - opcode localparams (OP_STATUS..OP_STOP_B);
  - status bytes (ST_OK=8'h11, ST_BAD=8'h10, ST_TMO=8'h12, ST_BADCH=8'h1F, DATA_ERR=8'hFF);
  - state encoding;
  - frame field offsets.
- Sub-module sensor_frame_check: combinational field split plus checksum on a 40-bit frame; one instance after the channel mux.

Test Plan:
- ch=2, op=01, driver 2 done with frame 40'h3700_1900_50 → requested_data=8'h19, data_strobe and finished pulse together, sensor_start[2] only.
- op=00, frame checksum 8'h51 (wrong) → 8'h10; same with 8'h50 → 8'h11.
- op=03, driver never responds, TIMEOUT_CYCLES=100 → finished at cycle 103 after enable, requested_data=8'hFF; op=00 → 8'h12.
- op=05, STREAM_PERIOD=50, temp 25.3 → strobes 8'h19, 8'h03, restart after 50 cycles; request=07 during STR_GAP → finished, no further strobes.
- channel=6 with NUM_CHANNELS=4 → 8'h1F, sensor_start stays 0; reset_n low during WAIT → all outputs 0, state IDLE next cycle.
- SENSOR_HUB_LAST_GOOD_EN: good read (hum 8'h37), then error on op=03 → 8'h37; same sequence without the macro → 8'hFF.
